// File: rtl/bottle_pkg.sv
// rtl/bottle_pkg.sv - shared constants, spawn table and state type for the bottle controller
// Contents: SPAWN_DEPTH, SPAWN_X/SPAWN_Y respawn table, hitbox offsets,
//           bottle_state_t, overlap() helper for half-open interval tests.
package bottle_pkg;

   localparam int SPAWN_DEPTH = 8;
   // Spawn pointer wraps by natural overflow, so SPAWN_DEPTH must stay a power of two.
   localparam int PTR_W = $clog2(SPAWN_DEPTH);

   localparam logic [9:0] SPAWN_X [SPAWN_DEPTH] = '{
      10'd296, 10'd70, 10'd200, 10'd450, 10'd120, 10'd560, 10'd330, 10'd40};
   localparam logic [9:0] SPAWN_Y [SPAWN_DEPTH] = '{
      10'd364, 10'd116, 10'd116, 10'd199, 10'd199, 10'd283, 10'd283, 10'd364};

   // Hitbox offsets, all relative to the top-left corner of the sprite.
   localparam logic [10:0] BOTTLE_HB = 11'd13;  // bottle hitbox edge length
   localparam logic [10:0] DIV_A_X0  = 11'd9;   // diver upper box
   localparam logic [10:0] DIV_A_X1  = 11'd16;
   localparam logic [10:0] DIV_A_Y1  = 11'd13;
   localparam logic [10:0] DIV_B_X1  = 11'd13;  // diver lower box
   localparam logic [10:0] DIV_B_Y0  = 11'd13;
   localparam logic [10:0] DIV_B_Y1  = 11'd18;
   localparam logic [10:0] SPRITE_SZ = 11'd16;  // drawn sprite edge length

   typedef enum logic {
      ACTIVE = 1'b0,
      HIDDEN = 1'b1
   } bottle_state_t;

   // Strict overlap of [a0,a1) and [b0,b1).
   function automatic logic overlap(input logic [10:0] a0, input logic [10:0] a1,
                                    input logic [10:0] b0, input logic [10:0] b1);
      return (a0 < b1) && (b0 < a1);
   endfunction

endpackage

// File: rtl/bottle_rom.sv
// rtl/bottle_rom.sv - 16x16 12-bit bottle sprite, asynchronous read
// Ports: addr[7:0] = {row, col}; color[11:0] texel colour, TRANSPARENT outside the bottle.
module bottle_rom #(
   parameter logic [11:0] TRANSPARENT = 12'h6DE
) (
   input  logic [7:0]  addr,
   output logic [11:0] color
);

   logic [3:0] row;
   logic [3:0] col;
   logic       opaque;

   assign row = addr[7:4];
   assign col = addr[3:0];

   // Narrow neck in rows 0-3, wide body below; shade encodes the texel position.
   assign opaque = ((row < 4'd4) && (col >= 4'd6) && (col < 4'd10)) ||
                   ((row >= 4'd4) && (col >= 4'd3) && (col < 4'd13));

   assign color = opaque ? {4'h2, row, col} : TRANSPARENT;

endmodule

// File: rtl/multi_bottle_controller.sv
// rtl/multi_bottle_controller.sv - N collectible bottles with collision, respawn, score and pixel layer
// Ports: clk, rst (async, active high), tick (frame strobe), d_x/d_y diver position,
//        x/y pixel coordinate, bottles_on/rgb_out pixel layer, collect_pulse, score.
module multi_bottle_controller
   import bottle_pkg::*;
#(
   parameter int          N_BOTTLES     = 4,
   parameter int          RESPAWN_DELAY = 60,
   parameter logic [11:0] TRANSPARENT   = 12'h6DE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic [9:0]  d_x,
   input  logic [9:0]  d_y,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   output logic        bottles_on,
   output logic [11:0] rgb_out,
   output logic        collect_pulse,
   output logic [7:0]  score
);

   localparam logic [9:0] DLY_LAST = 10'(RESPAWN_DELAY - 1);

   bottle_state_t           st     [N_BOTTLES];
   bottle_state_t           st_nxt [N_BOTTLES];
   logic [9:0]              cnt    [N_BOTTLES];
   logic [9:0]              cnt_nxt[N_BOTTLES];
   logic [9:0]              bx     [N_BOTTLES];
   logic [9:0]              bx_nxt [N_BOTTLES];
   logic [9:0]              by     [N_BOTTLES];
   logic [9:0]              by_nxt [N_BOTTLES];
   logic [PTR_W-1:0]        ptr, ptr_nxt, sidx;
   logic [N_BOTTLES-1:0]    hit;
   logic [3:0]              n_coll, n_resp;
   logic [8:0]              score_sum;
   logic [7:0]              score_nxt;
   logic                    pulse_nxt;

   logic [10:0] dx0, dy0;
   assign dx0 = {1'b0, d_x};
   assign dy0 = {1'b0, d_y};

   // Collision per bottle: 11-bit arithmetic so right/bottom edges never wrap.
   for (genvar g = 0; g < N_BOTTLES; g++) begin : g_hit
      logic [10:0] bx0, by0;
      logic        ovl_a, ovl_b;
      assign bx0   = {1'b0, bx[g]};
      assign by0   = {1'b0, by[g]};
      assign ovl_a = overlap(dx0 + DIV_A_X0, dx0 + DIV_A_X1, bx0, bx0 + BOTTLE_HB) &&
                     overlap(dy0, dy0 + DIV_A_Y1, by0, by0 + BOTTLE_HB);
      assign ovl_b = overlap(dx0, dx0 + DIV_B_X1, bx0, bx0 + BOTTLE_HB) &&
                     overlap(dy0 + DIV_B_Y0, dy0 + DIV_B_Y1, by0, by0 + BOTTLE_HB);
      assign hit[g] = (st[g] == ACTIVE) && (ovl_a || ovl_b);
   end

   // Next state for every bottle. Respawning bottles take consecutive table
   // entries from ptr in ascending index order; n_resp is the running offset.
   always_comb begin
      n_coll = '0;
      n_resp = '0;
      sidx   = '0;
      for (int i = 0; i < N_BOTTLES; i++) begin
         st_nxt[i]  = st[i];
         cnt_nxt[i] = cnt[i];
         bx_nxt[i]  = bx[i];
         by_nxt[i]  = by[i];
         if (tick) begin
            if (hit[i]) begin
               st_nxt[i]  = HIDDEN;
               cnt_nxt[i] = '0;
               n_coll     = n_coll + 4'd1;
            end else if (st[i] == HIDDEN) begin
               if (cnt[i] == DLY_LAST) begin
                  sidx       = ptr + n_resp[PTR_W-1:0];
                  bx_nxt[i]  = SPAWN_X[sidx];
                  by_nxt[i]  = SPAWN_Y[sidx];
                  st_nxt[i]  = ACTIVE;
                  cnt_nxt[i] = '0;
                  n_resp     = n_resp + 4'd1;
               end else begin
                  cnt_nxt[i] = cnt[i] + 10'd1;
               end
            end
         end
      end
      ptr_nxt   = ptr + n_resp[PTR_W-1:0];
      score_sum = {1'b0, score} + {5'b0, n_coll};
      score_nxt = score_sum[8] ? 8'hFF : score_sum[7:0];
      pulse_nxt = tick && (n_coll != 4'd0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_BOTTLES; i++) begin
            st[i]  <= ACTIVE;
            cnt[i] <= '0;
            bx[i]  <= SPAWN_X[PTR_W'(i % SPAWN_DEPTH)];
            by[i]  <= SPAWN_Y[PTR_W'(i % SPAWN_DEPTH)];
         end
         ptr           <= PTR_W'(N_BOTTLES % SPAWN_DEPTH);
         score         <= '0;
         collect_pulse <= 1'b0;
      end else begin
         for (int i = 0; i < N_BOTTLES; i++) begin
            st[i]  <= st_nxt[i];
            cnt[i] <= cnt_nxt[i];
            bx[i]  <= bx_nxt[i];
            by[i]  <= by_nxt[i];
         end
         ptr           <= ptr_nxt;
         score         <= score_nxt;
         collect_pulse <= pulse_nxt;
      end
   end

   // Pixel priority mux: scanned high to low so the lowest index is written last.
   logic        pix_hit;
   logic [7:0]  rom_addr;
   logic [11:0] rom_color;

   always_comb begin
      pix_hit  = 1'b0;
      rom_addr = '0;
      for (int i = N_BOTTLES - 1; i >= 0; i--) begin
         if ((st[i] == ACTIVE) &&
             ({1'b0, x} >= {1'b0, bx[i]}) && ({1'b0, x} < {1'b0, bx[i]} + SPRITE_SZ) &&
             ({1'b0, y} >= {1'b0, by[i]}) && ({1'b0, y} < {1'b0, by[i]} + SPRITE_SZ)) begin
            pix_hit  = 1'b1;
            // Only the low nibble of the offset matters inside a 16x16 sprite.
            rom_addr = {y[3:0] - by[i][3:0], x[3:0] - bx[i][3:0]};
         end
      end
   end

   bottle_rom #(
      .TRANSPARENT(TRANSPARENT)
   ) u_rom (
      .addr (rom_addr),
      .color(rom_color)
   );

   assign bottles_on = pix_hit && (rom_color != TRANSPARENT);
   assign rgb_out    = bottles_on ? rom_color : 12'h000;

endmodule

// File: doc/multi_bottle_controller.md
# multi_bottle_controller

Parametrised successor to the single-bottle pickup logic. Manages `N_BOTTLES` independent collectible bottles and detects diver collisions against each one. Each collected bottle respawns after a programmable frame delay at the next spawn location from a round-robin table. The block keeps a saturating score and drives the per-pixel bottle colour and overlay flag to the VGA pixel mux, alongside the diver and platform layers.

## Interface
Parameters:
- `N_BOTTLES`, 4: number of simultaneous bottles, 1..8.
- `RESPAWN_DELAY`, 60: ticks a collected bottle stays hidden, 1..1023.
- `TRANSPARENT`, 12'h6DE: ROM colour treated as see-through.

Ports:
- `clk`  in  1  system clock. One clock; all state is on `clk`.
- `rst`  in  1  asynchronous, active-high reset.
- `tick`  in  1  one-cycle game-update strobe, once per frame. State advances only when `tick`=1.
- `d_x`, `d_y`  in  10 each  diver top-left position.
- `x`, `y`  in  10 each  current pixel coordinate.
- `bottles_on`  out  1  current pixel is an opaque pixel of a visible bottle.
- `rgb_out`  out  12  bottle colour at pixel; 0 when `bottles_on`=0.
- `collect_pulse`  out  1  high for exactly one `clk` cycle on any tick with ≥1 collection.
- `score`  out  8  collected-bottle count, saturates at 255.

## Operation
- Per-bottle FSM with states ACTIVE and HIDDEN, plus a 10-bit delay counter and 10-bit x/y registers.
- ACTIVE → HIDDEN on a tick when the bottle hitbox overlaps the diver hitbox. The counter loads 0.
  - Bottle hitbox: [bx, bx+13) × [by, by+13).
  - Diver hitbox is the union of [d_x+9, d_x+16) × [d_y, d_y+13) and [d_x, d_x+13) × [d_y+13, d_y+18).
  - All comparisons are strict-overlap and unsigned, 11-bit so `+` never wraps.
- HIDDEN: the counter increments on each tick. When it equals `RESPAWN_DELAY-1` on a tick:
  - the bottle loads `SPAWN_X/Y[ptr]`;
  - the bottle returns to ACTIVE;
  - `ptr` advances mod `SPAWN_DEPTH`.
- A HIDDEN bottle never collides and is never drawn.
- Simultaneous collections on one tick: `score` += count of collecting bottles, saturating at 255; a single `collect_pulse`.
- Simultaneous respawns on one tick: bottles take consecutive table entries in ascending bottle index, starting at `ptr`. `ptr` advances by the respawn count, with wrap.
- Collection and respawn of different bottles on the same tick are independent.
- Pixel path:
  - Among visible bottles with x∈[bx, bx+16) and y∈[by, by+16), the lowest index wins.
  - ROM address is {y-by[3:0], x-bx[3:0]}.
  - `bottles_on` = hit && colour≠`TRANSPARENT`.

## Timing
- Reset values:
  - bottle i at `SPAWN_X/Y[i mod SPAWN_DEPTH]`, ACTIVE, counter 0;
  - `ptr` = `N_BOTTLES mod SPAWN_DEPTH`;
  - `score` = 0, `collect_pulse` = 0.
- `bottles_on` and `rgb_out` are combinational from `x`, `y` and the state registers, with zero latency. The ROM is asynchronous-read.
- Collision is sampled on the `clk` edge where `tick`=1. The state change, score update and `collect_pulse` are visible the cycle after.
- Respawn timing: bottle visible again exactly `RESPAWN_DELAY` ticks after the collecting tick.
- `rst` asserted mid-frame restores all reset values immediately, independent of `clk`. Pixel outputs reflect the reset positions while `rst` is high.
- `tick` held high on consecutive cycles is legal. Each cycle counts as one tick.

## Structure
- Package `bottle_pkg` holds:
  - `SPAWN_DEPTH` = 8;
  - `SPAWN_X/Y` arrays: (296,364), (70,116), (200,116), (450,199), (120,199), (560,283), (330,283), (40,364);
  - hitbox offset constants;
  - the FSM state enum.
- Sub-module `bottle_rom`: 16×16×12-bit combinational sprite ROM, port `addr[7:0]` → `color[11:0]`. One instance is shared by all bottles through the priority mux.
- Everything else is flat in `multi_bottle_controller`, with a generate loop per bottle.

## Test plan
- Reset, no ticks, `N_BOTTLES`=4:
  - pixel (300,368) → `bottles_on`=1 on an opaque ROM texel;
  - `score`=0, `ptr`=4.
- Diver at (290,360), one tick:
  - bottle 0 → HIDDEN, `score`=1, `collect_pulse` high one cycle;
  - pixel (300,368) → `bottles_on`=0.
- `RESPAWN_DELAY`=3, after the collection above:
  - bottle 0 reappears at (120,199) on the 3rd following tick, not the 2nd;
  - `ptr`=5.
- Bottles 0 and 1 forced to overlap the diver on the same tick:
  - `score` += 2, one `collect_pulse`;
  - respawns land at table entries 4 and 5 respectively;
  - `ptr` wraps correctly after index 7.
- `score` preloaded to 254 via repeated collections, then a double collection → `score`=255 and holds. Assert `rst` between `clk` edges → all outputs return to reset values immediately.
